lsu: RTL and testbench

Load/store unit directly downstream of the ALU in the execute stage: takes ALUResult as the effective address, issues one aligned word-granular request to data memory over a request/ready + rvalid handshake, and returns sign/zero-extended load data to writeback. It stalls the core while an access is in flight and flags misaligned or illegal accesses without touching the bus.

---
 rtl/lsu_pkg.sv | 22 ++
 rtl/lsu_align.sv | 52 +++++
 rtl/lsu.sv | 124 ++++++++++++
 tb/tb_lsu.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit.
// FSM states, Funct3 access encodings and base byte-enable patterns.
package lsu_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DONE
    } state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [3:0] BE_B = 4'b0001;
    localparam logic [3:0] BE_H = 4'b0011;
    localparam logic [3:0] BE_W = 4'b1111;

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: store byte enables / replicated data and
// load lane extraction with sign or zero extension.
module lsu_align
    import lsu_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [2:0]            st_funct3,
    input  logic [1:0]            st_off,
    input  logic [DATA_WIDTH-1:0] st_data,
    output logic [3:0]            be,
    output logic [DATA_WIDTH-1:0] wdata,
    input  logic [2:0]            ld_funct3,
    input  logic [1:0]            ld_off,
    input  logic [DATA_WIDTH-1:0] rdata,
    output logic [DATA_WIDTH-1:0] ld_data
);

    logic [DATA_WIDTH-1:0] lane;

    always_comb begin
        be    = BE_W;
        wdata = st_data;
        unique case (1'b1)
            (st_funct3 == F3_B) || (st_funct3 == F3_BU): begin
                be    = BE_B << st_off;
                wdata = {4{st_data[7:0]}};
            end
            (st_funct3 == F3_H) || (st_funct3 == F3_HU): begin
                be    = BE_H << {st_off[1], 1'b0};
                wdata = {2{st_data[15:0]}};
            end
            default: begin
                be    = BE_W;
                wdata = st_data;
            end
        endcase
    end

    always_comb begin
        lane    = rdata >> {ld_off, 3'b000};
        ld_data = lane;
        unique case (1'b1)
            ld_funct3 == F3_B:  ld_data = {{24{lane[7]}}, lane[7:0]};
            ld_funct3 == F3_BU: ld_data = {24'b0, lane[7:0]};
            ld_funct3 == F3_H:  ld_data = {{16{lane[15]}}, lane[15:0]};
            ld_funct3 == F3_HU: ld_data = {16'b0, lane[15:0]};
            default:            ld_data = lane;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// Execute-stage load/store unit: one aligned word request per access,
// stalls the core while in flight, flags illegal accesses off-bus.
module lsu
    import lsu_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  MemRead,
    input  logic                  MemWrite,
    input  logic [2:0]            Funct3,
    input  logic [DATA_WIDTH-1:0] ALUResult,
    input  logic [DATA_WIDTH-1:0] WriteData,
    output logic [DATA_WIDTH-1:0] ReadData,
    output logic                  Done,
    output logic                  Stall,
    output logic                  LsuErr,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [DATA_WIDTH-1:0] mem_addr,
    output logic [3:0]            mem_be,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_ready,
    input  logic                  mem_rvalid,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    state_t                state, next;
    logic                  op, bad, size_bad;
    logic                  cap, rd_cap;
    logic [3:0]            be_c;
    logic [DATA_WIDTH-1:0] wdata_c, ld_data;
    logic [2:0]            f3_q;
    logic [1:0]            off_q;
    logic                  err_q;

    assign op = MemRead | MemWrite;

    always_comb begin
        size_bad = 1'b0;
        unique case (1'b1)
            Funct3 == F3_B:  size_bad = 1'b0;
            Funct3 == F3_H:  size_bad = ALUResult[0];
            Funct3 == F3_W:  size_bad = |ALUResult[1:0];
            Funct3 == F3_BU: size_bad = MemWrite;
            Funct3 == F3_HU: size_bad = MemWrite | ALUResult[0];
            default:         size_bad = 1'b1;
        endcase
        bad = op & (size_bad | (MemRead & MemWrite));
    end

    lsu_align #(.DATA_WIDTH(DATA_WIDTH)) u_align (
        .st_funct3 (Funct3),
        .st_off    (ALUResult[1:0]),
        .st_data   (WriteData),
        .be        (be_c),
        .wdata     (wdata_c),
        .ld_funct3 (f3_q),
        .ld_off    (off_q),
        .rdata     (mem_rdata),
        .ld_data   (ld_data)
    );

    always_comb begin
        next   = state;
        cap    = 1'b0;
        rd_cap = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (op && !bad) begin
                    next = S_REQ;
                    cap  = 1'b1;
                end
            end
            S_REQ: begin
                if (mem_ready)
                    next = mem_we ? S_DONE : S_WAIT;
            end
            S_WAIT: begin
                if (mem_rvalid) begin
                    next   = S_DONE;
                    rd_cap = 1'b1;
                end
            end
            S_DONE:  next = S_IDLE;
            default: next = S_IDLE;
        endcase
    end

    assign mem_req = (state == S_REQ);
    assign Done    = (state == S_DONE);
    assign LsuErr  = err_q;
    // Illegal ops never stall, so the core moves on after the error pulse.
    assign Stall   = op & ~Done & ~bad;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            err_q     <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_be    <= '0;
            mem_wdata <= '0;
            f3_q      <= '0;
            off_q     <= '0;
            ReadData  <= '0;
        end else begin
            state <= next;
            err_q <= (state == S_IDLE) & bad;
            if (cap) begin
                mem_we    <= MemWrite;
                mem_addr  <= {ALUResult[DATA_WIDTH-1:2], 2'b00};
                mem_be    <= be_c;
                mem_wdata <= wdata_c;
                f3_q      <= Funct3;
                off_q     <= ALUResult[1:0];
            end
            if (rd_cap)
                ReadData <= ld_data;
        end
    end

endmodule

// File: tb/tb_lsu.sv
// Directed self-checking bench for lsu.
module tb_lsu;
    import lsu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        MemRead, MemWrite;
    logic [2:0]  Funct3;
    logic [31:0] ALUResult, WriteData;
    logic [31:0] ReadData;
    logic        Done, Stall, LsuErr;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ready, mem_rvalid;
    logic [31:0] mem_rdata;

    int npass = 0;
    int ntotal = 0;
    int nfail = 0;

    lsu #(.DATA_WIDTH(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .Funct3     (Funct3),
        .ALUResult  (ALUResult),
        .WriteData  (WriteData),
        .ReadData   (ReadData),
        .Done       (Done),
        .Stall      (Stall),
        .LsuErr     (LsuErr),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_be     (mem_be),
        .mem_wdata  (mem_wdata),
        .mem_ready  (mem_ready),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        ntotal++;
        assert (got === exp) npass++;
        else begin
            nfail++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic do_load(input string tag, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] rd,
                           input int lat, input logic [3:0] ebe,
                           input logic [31:0] exp);
        MemRead   = 1'b1;
        Funct3    = f3;
        ALUResult = a;
        #1;
        chk({tag, "_stall0"}, 32'(Stall), 32'd1);
        tick;
        chk({tag, "_req"}, 32'(mem_req), 32'd1);
        chk({tag, "_we"}, 32'(mem_we), 32'd0);
        chk({tag, "_addr"}, mem_addr, {a[31:2], 2'b00});
        chk({tag, "_be"}, 32'(mem_be), 32'(ebe));
        tick;
        for (int i = 0; i < lat; i++) begin
            chk({tag, "_wstall"}, 32'(Stall), 32'd1);
            chk({tag, "_wdone"}, 32'(Done), 32'd0);
            tick;
        end
        mem_rvalid = 1'b1;
        mem_rdata  = rd;
        tick;
        mem_rvalid = 1'b0;
        mem_rdata  = 32'h0;
        chk({tag, "_done"}, 32'(Done), 32'd1);
        chk({tag, "_data"}, ReadData, exp);
        chk({tag, "_stall_d"}, 32'(Stall), 32'd0);
        MemRead = 1'b0;
        tick;
        chk({tag, "_pulse"}, 32'(Done), 32'd0);
        chk({tag, "_hold"}, ReadData, exp);
    endtask

    initial begin
        rst_n      = 1'b0;
        MemRead    = 1'b0;
        MemWrite   = 1'b0;
        Funct3     = F3_W;
        ALUResult  = 32'h0;
        WriteData  = 32'h0;
        mem_ready  = 1'b1;
        mem_rvalid = 1'b0;
        mem_rdata  = 32'h0;
        tick;
        tick;
        chk("rst_req", 32'(mem_req), 32'd0);
        chk("rst_we", 32'(mem_we), 32'd0);
        chk("rst_done", 32'(Done), 32'd0);
        chk("rst_err", 32'(LsuErr), 32'd0);
        chk("rst_addr", mem_addr, 32'h0);
        chk("rst_be", 32'(mem_be), 32'h0);
        chk("rst_wdata", mem_wdata, 32'h0);
        chk("rst_rdata", ReadData, 32'h0);
        rst_n = 1'b1;
        tick;

        // SW 0xDEADBEEF -> 0x100, ready high
        MemWrite  = 1'b1;
        Funct3    = F3_W;
        ALUResult = 32'h100;
        WriteData = 32'hDEADBEEF;
        #1;
        chk("sw_stall0", 32'(Stall), 32'd1);
        chk("sw_req0", 32'(mem_req), 32'd0);
        tick;
        chk("sw_req1", 32'(mem_req), 32'd1);
        chk("sw_addr", mem_addr, 32'h100);
        chk("sw_be", 32'(mem_be), 32'hF);
        chk("sw_wdata", mem_wdata, 32'hDEADBEEF);
        chk("sw_we", 32'(mem_we), 32'd1);
        chk("sw_stall1", 32'(Stall), 32'd1);
        tick;
        chk("sw_done", 32'(Done), 32'd1);
        chk("sw_stall2", 32'(Stall), 32'd0);
        chk("sw_req2", 32'(mem_req), 32'd0);
        MemWrite = 1'b0;
        tick;
        chk("sw_pulse", 32'(Done), 32'd0);
        chk("sw_idle", 32'(mem_req), 32'd0);

        // SB 0xA5 -> 0x103, ready low three cycles
        mem_ready = 1'b0;
        MemWrite  = 1'b1;
        Funct3    = F3_B;
        ALUResult = 32'h103;
        WriteData = 32'h000000A5;
        tick;
        for (int i = 0; i < 3; i++) begin
            chk("sb_req", 32'(mem_req), 32'd1);
            chk("sb_addr", mem_addr, 32'h100);
            chk("sb_be", 32'(mem_be), 32'h8);
            chk("sb_wdata", mem_wdata, 32'hA5A5A5A5);
            chk("sb_done", 32'(Done), 32'd0);
            chk("sb_stall", 32'(Stall), 32'd1);
            tick;
        end
        mem_ready = 1'b1;
        #1;
        chk("sb_req_acc", 32'(mem_req), 32'd1);
        tick;
        chk("sb_done_acc", 32'(Done), 32'd1);
        MemWrite = 1'b0;
        tick;
        chk("sb_pulse", 32'(Done), 32'd0);

        // Loads, zero-wait
        do_load("lb", F3_B, 32'h102, 32'h00800000, 0, 4'b0100, 32'hFFFFFF80);
        do_load("lbu", F3_BU, 32'h102, 32'h00800000, 0, 4'b0100, 32'h00000080);
        do_load("lhu", F3_HU, 32'h102, 32'hBEEF0000, 0, 4'b1100, 32'h0000BEEF);
        do_load("lh", F3_H, 32'h102, 32'hBEEF0000, 0, 4'b1100, 32'hFFFFBEEF);

        // Misaligned LW
        MemRead   = 1'b1;
        Funct3    = F3_W;
        ALUResult = 32'h102;
        #1;
        chk("lwm_stall", 32'(Stall), 32'd0);
        chk("lwm_err0", 32'(LsuErr), 32'd0);
        tick;
        chk("lwm_err1", 32'(LsuErr), 32'd1);
        chk("lwm_req", 32'(mem_req), 32'd0);
        MemRead = 1'b0;
        tick;
        chk("lwm_err2", 32'(LsuErr), 32'd0);
        chk("lwm_req2", 32'(mem_req), 32'd0);

        // Read and write together
        MemRead   = 1'b1;
        MemWrite  = 1'b1;
        ALUResult = 32'h100;
        #1;
        chk("rw_stall", 32'(Stall), 32'd0);
        tick;
        chk("rw_err1", 32'(LsuErr), 32'd1);
        chk("rw_req", 32'(mem_req), 32'd0);
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        tick;
        chk("rw_err2", 32'(LsuErr), 32'd0);

        // BU on a store
        MemWrite = 1'b1;
        Funct3   = F3_BU;
        #1;
        chk("sbu_stall", 32'(Stall), 32'd0);
        tick;
        chk("sbu_err", 32'(LsuErr), 32'd1);
        chk("sbu_req", 32'(mem_req), 32'd0);
        MemWrite = 1'b0;
        tick;

        // Stray rvalid in IDLE
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hFFFFFFFF;
        tick;
        chk("stray_done", 32'(Done), 32'd0);
        chk("stray_req", 32'(mem_req), 32'd0);
        chk("stray_hold", ReadData, 32'hFFFFBEEF);
        mem_rvalid = 1'b0;
        mem_rdata  = 32'h0;
        tick;
        chk("stray_done2", 32'(Done), 32'd0);

        // rvalid four cycles after acceptance
        do_load("lw_slow", F3_W, 32'h200, 32'h12345678, 3, 4'b1111, 32'h12345678);

        // Reset while waiting for read data
        MemRead   = 1'b1;
        Funct3    = F3_W;
        ALUResult = 32'h300;
        tick;
        tick;
        chk("rw_wait_stall", 32'(Stall), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("arst_req", 32'(mem_req), 32'd0);
        chk("arst_done", 32'(Done), 32'd0);
        chk("arst_addr", mem_addr, 32'h0);
        chk("arst_be", 32'(mem_be), 32'h0);
        chk("arst_rdata", ReadData, 32'h0);
        MemRead = 1'b0;
        tick;
        rst_n = 1'b1;
        tick;
        do_load("lb_after", F3_B, 32'h301, 32'h0000AB00, 0, 4'b0010, 32'hFFFFFFAB);

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
